axi_slave_port_arbiter: RTL and testbench
=========================================

Name: axi_slave_port_arbiter

Overview:
- Sits between the Zynq PS general-purpose AXI master (32-bit data, 12-bit IDs, AXI4 bursts) and a single-port register backend inside mkTop.
- Accepts AW/W/B and AR/R transactions and arbitrates round-robin between the write and read paths.
- Splits each burst into per-beat backend accesses, one at a time, and returns B and R responses with the request ID echoed.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width (fixed 32; size code 2)
ID_W, 12, AXI ID width
REG_AW, 10, backend word-address width (window = 4*2^REG_AW bytes from address 0, upper bits masked)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
axi_slave_awvalid/awready  in/out  1  write address handshake
axi_slave_awaddr  in  ADDR_W  write start address
axi_slave_awlen  in  8  beats-1
axi_slave_awsize  in  3  beat size
axi_slave_awburst  in  2  burst type
axi_slave_awid  in  ID_W  write ID
axi_slave_wvalid/wready  in/out  1  write data handshake
axi_slave_wdata  in  DATA_W  write data
axi_slave_wstrb  in  4  byte strobes
axi_slave_wlast  in  1  last beat marker
axi_slave_bvalid/bready  out/in  1  write response handshake
axi_slave_bid  out  ID_W  echoed awid
axi_slave_bresp  out  2  response code
axi_slave_arvalid/arready  in/out  1  read address handshake
axi_slave_araddr  in  ADDR_W  read start address
axi_slave_arlen  in  8  beats-1
axi_slave_arsize  in  3  beat size
axi_slave_arburst  in  2  burst type
axi_slave_arid  in  ID_W  read ID
axi_slave_rvalid/rready  out/in  1  read data handshake
axi_slave_rdata  out  DATA_W  read data
axi_slave_rid  out  ID_W  echoed arid
axi_slave_rresp  out  2  response code
axi_slave_rlast  out  1  final read beat
reg_req_valid/reg_req_ready  out/in  1  backend request handshake
reg_req_write  out  1  1=write, 0=read
reg_req_addr  out  REG_AW  word address
reg_req_wdata  out  DATA_W  write data
reg_req_wstrb  out  4  write strobes
reg_rsp_valid  in  1  read data valid (reads only, 1 cycle pulse)
reg_rsp_rdata  in  DATA_W  read data

Behaviour:
- Reset (RST_N low at a CLK edge): state IDLE. All valid/ready outputs 0; bid, rid, rdata, bresp, rresp, reg_req_* all 0. Last-grant flag = READ, so the first contention goes to write. An in-flight burst is abandoned with no response.
- States: IDLE, W_DATA, W_REQ, W_RESP, R_REQ, R_WAIT, R_DATA.
- IDLE:
  - awready = awvalid & grant_w; arready = arvalid & !grant_w.
  - grant_w = awvalid & (!arvalid | last_grant==READ).
  - On accept: latch id, word address = addr[REG_AW+1:2], len, burst; clear beat counter; toggle last_grant; go to W_DATA or R_REQ.
- W_DATA: wready=1. On wvalid, latch wdata/wstrb and go to W_REQ.
- W_REQ: reg_req_valid=1, write=1. On reg_req_ready:
  - if beat==len, go to W_RESP;
  - else increment beat (and the address if burst != FIXED) and return to W_DATA.
- W_RESP: bvalid=1, bresp=00 until bready, then IDLE.
- R_REQ: reg_req_valid=1, write=0. On reg_req_ready, go to R_WAIT.
- R_WAIT: on reg_rsp_valid, register rdata and go to R_DATA.
- R_DATA: rvalid=1, rlast=(beat==len), rresp=00. On rready: IDLE if last; else step the address as for writes and go to R_REQ.
- Burst and beat rules:
  - WRAP bursts are treated as INCR.
  - Address increment is +1 word, wrapping modulo 2^REG_AW.
  - Burst termination uses the beat counter only; wlast is ignored.
- Minimum timing: AW accept to first backend write = 2 cycles with wvalid held. AR accept to rvalid = 2 cycles plus backend latency.
- Single outstanding transaction at any time. AW/AR never accepted outside IDLE. Outputs and latched values are stable while a valid is waiting for its ready.

Optional Feature:
SLVERR_EN
- Defined: the following set the error flag for the burst:
  - size != 2;
  - address bits [ADDR_W-1:REG_AW+2] nonzero;
  - for writes, wlast disagreeing with beat==len.
- With the flag set:
  - errored beats skip the backend: W_REQ and R_REQ/R_WAIT are bypassed;
  - an errored read beat returns rdata=0, rresp=10;
  - bresp=10 if any write beat errored.
- Undefined: no checks; upper address bits are masked; responses are always 00.

Test Plan:
- Single write: AW addr 0x10, len 0, id 0x5A; W data 0xDEADBEEF, strb F -> one backend write, addr 4, data DEADBEEF; then bvalid with bid 0x5A, bresp 00.
- Read burst: AR addr 0x20, len 3, INCR; backend returns A,B,C,D -> backend addrs 8,9,10,11; rdata A..D with rlast only on beat 3; rid echoed.
- Contention: AW and AR valid in the same cycle, repeated 4 times -> grants alternate W,R,W,R starting with write after reset.
- Backpressure: hold reg_req_ready low 5 cycles and rready low 3 cycles -> request and R outputs stay stable; no duplicate backend access; data unchanged.
- FIXED burst: write len 2 at 0x40 -> three backend writes, all at addr 0x10.
- Reset mid-read: drop RST_N during R_WAIT -> rvalid=0 and IDLE next cycle; a new AR after reset completes normally (SLVERR_EN build: AR addr 0x1000, REG_AW=10 -> rresp 10, no backend request).

Source files
------------

// File: rtl/axi_slave_port_arbiter.sv
// AXI4 slave port: round-robin AW/AR arbitration, per-beat register backend.
// Build option: define SLVERR_EN for size/range/wlast checks with SLVERR.
//
// Ports (names fixed by the PS-side wrapper):
//   CLK, RST_N            clock, synchronous active-low reset
//   axi_slave_aw*/w*/b*   AXI4 write address, data and response channels
//   axi_slave_ar*/r*      AXI4 read address and data channels
//   reg_req_*             one-at-a-time backend request (ready handshake)
//   reg_rsp_*             backend read data, single-cycle valid pulse
module axi_slave_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 12,
  parameter int REG_AW = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              axi_slave_awvalid,
  output logic              axi_slave_awready,
  input  logic [ADDR_W-1:0] axi_slave_awaddr,
  input  logic [7:0]        axi_slave_awlen,
  input  logic [2:0]        axi_slave_awsize,
  input  logic [1:0]        axi_slave_awburst,
  input  logic [ID_W-1:0]   axi_slave_awid,
  input  logic              axi_slave_wvalid,
  output logic              axi_slave_wready,
  input  logic [DATA_W-1:0] axi_slave_wdata,
  input  logic [3:0]        axi_slave_wstrb,
  input  logic              axi_slave_wlast,
  output logic              axi_slave_bvalid,
  input  logic              axi_slave_bready,
  output logic [ID_W-1:0]   axi_slave_bid,
  output logic [1:0]        axi_slave_bresp,
  input  logic              axi_slave_arvalid,
  output logic              axi_slave_arready,
  input  logic [ADDR_W-1:0] axi_slave_araddr,
  input  logic [7:0]        axi_slave_arlen,
  input  logic [2:0]        axi_slave_arsize,
  input  logic [1:0]        axi_slave_arburst,
  input  logic [ID_W-1:0]   axi_slave_arid,
  output logic              axi_slave_rvalid,
  input  logic              axi_slave_rready,
  output logic [DATA_W-1:0] axi_slave_rdata,
  output logic [ID_W-1:0]   axi_slave_rid,
  output logic [1:0]        axi_slave_rresp,
  output logic              axi_slave_rlast,
  output logic              reg_req_valid,
  input  logic              reg_req_ready,
  output logic              reg_req_write,
  output logic [REG_AW-1:0] reg_req_addr,
  output logic [DATA_W-1:0] reg_req_wdata,
  output logic [3:0]        reg_req_wstrb,
  input  logic              reg_rsp_valid,
  input  logic [DATA_W-1:0] reg_rsp_rdata
);

`ifdef SLVERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_REQ, W_RESP, R_REQ, R_WAIT, R_DATA
  } state_e;

  state_e            st_q, st_d;
  logic              lg_rd_q, lg_rd_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic              fixed_q, fixed_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              berr_q, berr_d;

  logic              grant_w;
  logic              last_beat;
  logic              aw_err;
  logic              ar_err;
  logic [REG_AW-1:0] addr_nx;

  // Ties go to whichever side did not win last time.
  assign grant_w = axi_slave_awvalid &
                   (!axi_slave_arvalid | lg_rd_q);

  assign last_beat = (beat_q == len_q);
  assign addr_nx   = fixed_q ? addr_q : addr_q + REG_AW'(1);

  assign aw_err = ErrEn &
    ((axi_slave_awsize != 3'd2) |
     (axi_slave_awaddr[ADDR_W-1:REG_AW+2] != '0));
  assign ar_err = ErrEn &
    ((axi_slave_arsize != 3'd2) |
     (axi_slave_araddr[ADDR_W-1:REG_AW+2] != '0));

  assign axi_slave_bid  = id_q;
  assign axi_slave_rid  = id_q;
  assign axi_slave_rdata = rdata_q;
  assign reg_req_addr  = addr_q;
  assign reg_req_wdata = wdata_q;
  assign reg_req_wstrb = wstrb_q;

  always_comb begin
    st_d    = st_q;
    lg_rd_d = lg_rd_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    fixed_d = fixed_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    berr_d  = berr_q;
    axi_slave_awready = 1'b0;
    axi_slave_arready = 1'b0;
    axi_slave_wready  = 1'b0;
    axi_slave_bvalid  = 1'b0;
    axi_slave_bresp   = 2'b00;
    axi_slave_rvalid  = 1'b0;
    axi_slave_rresp   = 2'b00;
    axi_slave_rlast   = 1'b0;
    reg_req_valid     = 1'b0;
    reg_req_write     = 1'b0;
    unique case (st_q)
      IDLE: begin
        axi_slave_awready = grant_w;
        axi_slave_arready = axi_slave_arvalid & !grant_w;
        if (grant_w) begin
          id_d    = axi_slave_awid;
          addr_d  = axi_slave_awaddr[REG_AW+1:2];
          len_d   = axi_slave_awlen;
          fixed_d = (axi_slave_awburst == 2'b00);
          beat_d  = '0;
          lg_rd_d = 1'b0;
          err_d   = aw_err;
          berr_d  = aw_err;
          st_d    = W_DATA;
        end else if (axi_slave_arvalid) begin
          id_d    = axi_slave_arid;
          addr_d  = axi_slave_araddr[REG_AW+1:2];
          len_d   = axi_slave_arlen;
          fixed_d = (axi_slave_arburst == 2'b00);
          beat_d  = '0;
          lg_rd_d = 1'b1;
          err_d   = ar_err;
          berr_d  = 1'b0;
          rdata_d = '0;
          // Errored reads never touch the backend.
          st_d    = ar_err ? R_DATA : R_REQ;
        end
      end
      W_DATA: begin
        axi_slave_wready = 1'b1;
        if (axi_slave_wvalid) begin
          wdata_d = axi_slave_wdata;
          wstrb_d = axi_slave_wstrb;
          if (ErrEn &
              (err_q | (axi_slave_wlast != last_beat))) begin
            // Errored beat: consumed here, no backend write.
            berr_d = 1'b1;
            if (last_beat) begin
              st_d = W_RESP;
            end else begin
              beat_d = beat_q + 8'd1;
              addr_d = addr_nx;
            end
          end else begin
            st_d = W_REQ;
          end
        end
      end
      W_REQ: begin
        reg_req_valid = 1'b1;
        reg_req_write = 1'b1;
        if (reg_req_ready) begin
          if (last_beat) begin
            st_d = W_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_nx;
            st_d   = W_DATA;
          end
        end
      end
      W_RESP: begin
        axi_slave_bvalid = 1'b1;
        axi_slave_bresp  = berr_q ? 2'b10 : 2'b00;
        if (axi_slave_bready) st_d = IDLE;
      end
      R_REQ: begin
        reg_req_valid = 1'b1;
        if (reg_req_ready) st_d = R_WAIT;
      end
      R_WAIT: begin
        if (reg_rsp_valid) begin
          rdata_d = reg_rsp_rdata;
          st_d    = R_DATA;
        end
      end
      R_DATA: begin
        axi_slave_rvalid = 1'b1;
        axi_slave_rlast  = last_beat;
        axi_slave_rresp  = err_q ? 2'b10 : 2'b00;
        if (axi_slave_rready) begin
          if (last_beat) begin
            st_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_nx;
            if (err_q) begin
              rdata_d = '0;
              st_d    = R_DATA;
            end else begin
              st_d = R_REQ;
            end
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q    <= IDLE;
      lg_rd_q <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      fixed_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      lg_rd_q <= lg_rd_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      fixed_q <= fixed_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      berr_q  <= berr_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_port_arbiter.sv
// Directed bench for axi_slave_port_arbiter.
// Backend model: register array with stall and read-latency knobs.
module tb_axi_slave_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [11:0] awid;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [11:0] arid;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [11:0] rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [1024];
  logic        acc_w [$];
  logic [9:0]  acc_a [$];
  logic [31:0] acc_d [$];
  int          stall = 0;
  int          rd_delay = 0;
  int          rd_cnt = 0;
  logic [31:0] rd_data;

  always #5 CLK = ~CLK;

  axi_slave_port_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .axi_slave_awvalid(awvalid), .axi_slave_awready(awready),
    .axi_slave_awaddr(awaddr), .axi_slave_awlen(awlen),
    .axi_slave_awsize(awsize), .axi_slave_awburst(awburst),
    .axi_slave_awid(awid),
    .axi_slave_wvalid(wvalid), .axi_slave_wready(wready),
    .axi_slave_wdata(wdata), .axi_slave_wstrb(wstrb),
    .axi_slave_wlast(wlast),
    .axi_slave_bvalid(bvalid), .axi_slave_bready(bready),
    .axi_slave_bid(bid), .axi_slave_bresp(bresp),
    .axi_slave_arvalid(arvalid), .axi_slave_arready(arready),
    .axi_slave_araddr(araddr), .axi_slave_arlen(arlen),
    .axi_slave_arsize(arsize), .axi_slave_arburst(arburst),
    .axi_slave_arid(arid),
    .axi_slave_rvalid(rvalid), .axi_slave_rready(rready),
    .axi_slave_rdata(rdata), .axi_slave_rid(rid),
    .axi_slave_rresp(rresp), .axi_slave_rlast(rlast),
    .reg_req_valid(req_valid), .reg_req_ready(req_ready),
    .reg_req_write(req_write), .reg_req_addr(req_addr),
    .reg_req_wdata(req_wdata), .reg_req_wstrb(req_wstrb),
    .reg_rsp_valid(rsp_valid), .reg_rsp_rdata(rsp_rdata)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backend: acts at negedges; a handshake seen here completes
  // at the following posedge.
  initial begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(negedge CLK);
      rsp_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = rd_data;
        end
      end
      req_ready = (stall == 0);
      if (req_valid) begin
        if (stall > 0) begin
          stall--;
        end else begin
          acc_w.push_back(req_write);
          acc_a.push_back(req_addr);
          acc_d.push_back(req_wdata);
          if (req_write) begin
            mem[req_addr] = req_wdata;
          end else begin
            rd_data = mem[req_addr];
            rd_cnt  = 1 + rd_delay;
          end
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [11:0] id);
    awvalid = 1'b1; awaddr = a; awlen = l;
    awburst = b; awid = id;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (awready) break;
      @(negedge CLK);
    end
    check("aw_hs", awready, 1);
    @(negedge CLK);
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [11:0] id);
    arvalid = 1'b1; araddr = a; arlen = l;
    arburst = b; arid = id;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (arready) break;
      @(negedge CLK);
    end
    check("ar_hs", arready, 1);
    @(negedge CLK);
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic last);
    wvalid = 1'b1; wdata = d; wstrb = 4'hF; wlast = last;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (wready) break;
      @(negedge CLK);
    end
    check("w_hs", wready, 1);
    @(negedge CLK);
    wvalid = 1'b0;
  endtask

  task automatic get_b(input logic [11:0] id, input logic [1:0] rsp);
    bready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bvalid) break;
      @(negedge CLK);
    end
    check("b_hs", bvalid, 1);
    check("bid", bid, id);
    check("bresp", bresp, rsp);
    @(negedge CLK);
    bready = 1'b0;
  endtask

  task automatic get_r(input logic [31:0] d, input logic last,
                       input logic [11:0] id, input logic [1:0] rsp);
    rready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (rvalid) break;
      @(negedge CLK);
    end
    check("r_hs", rvalid, 1);
    check("rdata", rdata, d);
    check("rlast", rlast, last);
    check("rid", rid, id);
    check("rresp", rresp, rsp);
    @(negedge CLK);
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rv [4];
    int base;
    rv[0] = 32'hAAAA0001; rv[1] = 32'hBBBB0002;
    rv[2] = 32'hCCCC0003; rv[3] = 32'hDDDD0004;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    RST_N = 1'b0;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 3'd2;
    awburst = 2'b01; awid = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 3'd2;
    arburst = 2'b01; arid = 0; rready = 0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_reqv", req_valid, 0);
    check("rst_ids", {bid, rid}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_reqaddr", req_addr, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // single write
    base = acc_a.size();
    send_aw(32'h10, 8'd0, 2'b01, 12'h5A);
    send_w(32'hDEADBEEF, 1'b1);
    get_b(12'h5A, 2'b00);
    check("sw_cnt", acc_a.size() - base, 1);
    check("sw_wr", acc_w[base], 1);
    check("sw_addr", acc_a[base], 10'd4);
    check("sw_data", acc_d[base], 32'hDEADBEEF);

    // read burst
    for (int i = 0; i < 4; i++) mem[8+i] = rv[i];
    base = acc_a.size();
    send_ar(32'h20, 8'd3, 2'b01, 12'h123);
    for (int i = 0; i < 4; i++)
      get_r(rv[i], i == 3, 12'h123, 2'b00);
    check("rb_cnt", acc_a.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("rb_addr", acc_a[base+i], 10'(8 + i));
      check("rb_rd", acc_w[base+i], 0);
    end

    // contention: W,R,W,R
    mem[1] = 32'h11111111;
    for (int r = 0; r < 4; r++) begin
      awvalid = 1; awaddr = 32'h0; awlen = 0;
      awburst = 2'b01; awid = 12'(r);
      arvalid = 1; araddr = 32'h4; arlen = 0;
      arburst = 2'b01; arid = 12'(16 + r);
      #1;
      check("ct_awready", awready, (r % 2) == 0);
      check("ct_arready", arready, (r % 2) == 1);
      @(negedge CLK);
      awvalid = 0; arvalid = 0;
      if ((r % 2) == 0) begin
        send_w(32'hC0FFEE00 + 32'(r), 1'b1);
        get_b(12'(r), 2'b00);
      end else begin
        get_r(32'h11111111, 1'b1, 12'(16 + r), 2'b00);
      end
    end
    check("ct_mem0", mem[0], 32'hC0FFEE02);

    // backpressure
    mem[12] = 32'h5555AAAA;
    stall = 5;
    base = acc_a.size();
    send_ar(32'h30, 8'd0, 2'b01, 12'h0BB);
    for (int i = 0; i < 5; i++) begin
      check("bp_reqv", req_valid, 1);
      check("bp_addr", req_addr, 10'd12);
      @(negedge CLK);
    end
    for (int i = 0; i < 20; i++) begin
      if (rvalid) break;
      @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_rvalid", rvalid, 1);
      check("bp_rdata", rdata, 32'h5555AAAA);
      @(negedge CLK);
    end
    get_r(32'h5555AAAA, 1'b1, 12'h0BB, 2'b00);
    check("bp_cnt", acc_a.size() - base, 1);

    // fixed burst
    base = acc_a.size();
    send_aw(32'h40, 8'd2, 2'b00, 12'h007);
    for (int i = 0; i < 3; i++)
      send_w(32'h1000 + 32'(i), i == 2);
    get_b(12'h007, 2'b00);
    check("fx_cnt", acc_a.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check("fx_addr", acc_a[base+i], 10'h10);
      check("fx_data", acc_d[base+i], 32'h1000 + 32'(i));
    end

    // reset while waiting on backend read data
    rd_delay = 5;
    send_ar(32'h50, 8'd0, 2'b01, 12'h0CC);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    #1;
    check("mr_rvalid", rvalid, 0);
    check("mr_reqv", req_valid, 0);
    check("mr_rdata", rdata, 0);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    rd_delay = 0;
    base = acc_a.size();
    send_ar(32'h1000, 8'd0, 2'b01, 12'h0DD);
`ifdef SLVERR_EN
    get_r(32'h0, 1'b1, 12'h0DD, 2'b10);
    check("mr_cnt", acc_a.size() - base, 0);
`else
    get_r(32'hC0FFEE02, 1'b1, 12'h0DD, 2'b00);
    check("mr_cnt", acc_a.size() - base, 1);
    check("mr_addr", acc_a[base], 10'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
